// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU/shifter, status flags, jump/branch address, store data.
// Optional iterative multiplier compiled in when EX_MUL_EN is defined.
module ex_stage_pipe #(
  parameter int  WIDTH  = 32,
  parameter int  ADDR_W = 16,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  ABUS,
  input  logic [WIDTH-1:0]  BBUS,
  input  logic [ADDR_W-1:0] PCN2,
  input  logic              MW,
  input  logic [4:0]        FS,
  input  logic [SHW-1:0]    SH,
  output logic              out_valid,
  output logic [WIDTH-1:0]  F,
  output logic [WIDTH-1:0]  data,
  output logic [ADDR_W-1:0] RAA,
  output logic [ADDR_W-1:0] BrA,
  output logic              MW_out,
  output logic              V,
  output logic              C,
  output logic              N,
  output logic              Z,
  output logic              NXORV,
  output logic              LCO,
  output logic              RCO
);

  typedef enum logic [4:0] {
    OP_MOVA = 5'b00000, OP_INC = 5'b00001, OP_ADD = 5'b00010, OP_SUB = 5'b00101,
    OP_DEC  = 5'b00110, OP_AND = 5'b01000, OP_OR  = 5'b01010, OP_XOR = 5'b01100,
    OP_NOT  = 5'b01110, OP_MOVB = 5'b10000, OP_SRL = 5'b10100, OP_SRA = 5'b10110,
    OP_SLL  = 5'b11000, OP_MUL = 5'b11100
  } op_t;

  op_t op;
  assign op = op_t'(FS);

  logic [WIDTH-1:0] bop, alu_f;
  logic [WIDTH:0]   sum;
  logic             cin, arith, alu_c, alu_v, alu_lco, alu_rco;

  // INC/ADD/SUB/DEC share one adder: A + bop + cin
  always_comb begin
    bop   = '0;
    cin   = 1'b0;
    arith = 1'b0;
    case (op)
      OP_INC:  begin arith = 1'b1; cin = 1'b1; end
      OP_ADD:  begin arith = 1'b1; bop = BBUS; end
      OP_SUB:  begin arith = 1'b1; bop = ~BBUS; cin = 1'b1; end
      OP_DEC:  begin arith = 1'b1; bop = '1; end
      default: ;
    endcase
    sum   = {1'b0, ABUS} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
    alu_c = arith & sum[WIDTH];
    alu_v = arith & (ABUS[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != ABUS[WIDTH-1]);

    alu_f = '0;
    case (op)
      OP_MOVA:                        alu_f = ABUS;
      OP_INC, OP_ADD, OP_SUB, OP_DEC: alu_f = sum[WIDTH-1:0];
      OP_AND:                         alu_f = ABUS & BBUS;
      OP_OR:                          alu_f = ABUS | BBUS;
      OP_XOR:                         alu_f = ABUS ^ BBUS;
      OP_NOT:                         alu_f = ~ABUS;
      OP_MOVB:                        alu_f = BBUS;
      OP_SRL:                         alu_f = ABUS >> SH;
      OP_SRA:                         alu_f = $unsigned($signed(ABUS) >>> SH);
      OP_SLL:                         alu_f = ABUS << SH;
      default:                        alu_f = '0;
    endcase
    alu_lco = (op == OP_SLL) && (SH != '0) && ABUS[SHW'(WIDTH - int'(SH))];
    alu_rco = (op == OP_SRL || op == OP_SRA) && (SH != '0) && ABUS[SH - SHW'(1)];
  end

`ifdef EX_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mplier, mul_a, mul_b;
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [ADDR_W-1:0]  mul_pc;
  logic               mul_mw, start;

  assign in_ready  = (state == S_IDLE);
  assign start     = in_valid & in_ready & (op == OP_MUL);
  assign prod_next = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_MUL;
      S_MUL:   if (count == CW'(1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_pc <= '0;
      mul_mw <= 1'b0;
    end else if (start) begin
      count  <= CW'(WIDTH);
      mplier <= ABUS;
      mcand  <= {{WIDTH{1'b0}}, BBUS};
      prod   <= '0;
      mul_a  <= ABUS;
      mul_b  <= BBUS;
      mul_pc <= PCN2;
      mul_mw <= MW;
    end else if (state == S_MUL) begin
      count  <= count - CW'(1);
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      prod   <= prod_next;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  logic             load, res_mw, res_c, res_v, res_lco, res_rco;
  logic [WIDTH-1:0] res_f, res_a, res_b;
  logic [ADDR_W-1:0] res_pc;

  always_comb begin
    load    = in_valid & in_ready;
    res_f   = alu_f;
    res_c   = alu_c;
    res_v   = alu_v;
    res_lco = alu_lco;
    res_rco = alu_rco;
    res_a   = ABUS;
    res_b   = BBUS;
    res_pc  = PCN2;
    res_mw  = MW;
`ifdef EX_MUL_EN
    // MUL results come from the latched operands on the final shift-add edge
    if (state == S_MUL) begin
      load    = (count == CW'(1));
      res_f   = prod_next[WIDTH-1:0];
      res_c   = |prod_next[2*WIDTH-1:WIDTH];
      res_v   = |prod_next[2*WIDTH-1:WIDTH];
      res_lco = 1'b0;
      res_rco = 1'b0;
      res_a   = mul_a;
      res_b   = mul_b;
      res_pc  = mul_pc;
      res_mw  = mul_mw;
    end else if (op == OP_MUL) begin
      load = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      MW_out    <= 1'b0;
      F         <= '0;
      data      <= '0;
      RAA       <= '0;
      BrA       <= '0;
      V         <= 1'b0;
      C         <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
      NXORV     <= 1'b0;
      LCO       <= 1'b0;
      RCO       <= 1'b0;
    end else begin
      out_valid <= load;
      MW_out    <= load & res_mw;
      if (load) begin
        F     <= res_f;
        data  <= res_b;
        RAA   <= res_a[ADDR_W-1:0];
        BrA   <= res_pc + res_b[ADDR_W-1:0];
        V     <= res_v;
        C     <= res_c;
        N     <= res_f[WIDTH-1];
        Z     <= (res_f == '0);
        NXORV <= res_f[WIDTH-1] ^ res_v;
        LCO   <= res_lco;
        RCO   <= res_rco;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed vector table, randomized ops against a
// reference model, and multiplier/reset sequences when EX_MUL_EN is defined.
module tb_ex_stage_pipe;
  localparam int W  = 32;
  localparam int AW = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, MW, out_valid, MW_out;
  logic [W-1:0]  ABUS, BBUS, F, data;
  logic [AW-1:0] PCN2, RAA, BrA;
  logic [4:0]    FS;
  logic [SW-1:0] SH;
  logic          V, C, N, Z, NXORV, LCO, RCO;

  ex_stage_pipe #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ABUS(ABUS), .BBUS(BBUS), .PCN2(PCN2), .MW(MW), .FS(FS), .SH(SH),
    .out_valid(out_valid), .F(F), .data(data), .RAA(RAA), .BrA(BrA), .MW_out(MW_out),
    .V(V), .C(C), .N(N), .Z(Z), .NXORV(NXORV), .LCO(LCO), .RCO(RCO)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  typedef struct packed {
    logic [31:0] f;
    logic v, c, n, z, nxv, lco, rco;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic [15:0] pc;
    logic        mw;
    logic [4:0]  fs;
    logic [4:0]  sh;
    logic [31:0] f;
    logic        v, c, n, z, lco, rco;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc,
                       input logic mw, input logic [4:0] fs, input logic [4:0] sh, input logic v);
    ABUS = a; BBUS = b; PCN2 = pc; MW = mw; FS = fs; SH = sh; in_valid = v;
  endtask

  task automatic chk_res(input string nm, input res_t e, input logic [31:0] d,
                         input logic [15:0] raa, input logic [15:0] bra,
                         input logic mwo, input logic ov);
    chk({nm, ".out_valid"}, out_valid, ov);
    chk({nm, ".F"}, F, e.f);
    chk({nm, ".V"}, V, e.v);
    chk({nm, ".C"}, C, e.c);
    chk({nm, ".N"}, N, e.n);
    chk({nm, ".Z"}, Z, e.z);
    chk({nm, ".NXORV"}, NXORV, e.nxv);
    chk({nm, ".LCO"}, LCO, e.lco);
    chk({nm, ".RCO"}, RCO, e.rco);
    chk({nm, ".data"}, data, d);
    chk({nm, ".RAA"}, RAA, raa);
    chk({nm, ".BrA"}, BrA, bra);
    chk({nm, ".MW_out"}, MW_out, mwo);
  endtask

  task automatic chk_zero(input string nm);
    chk_res(nm, '0, '0, '0, '0, 1'b0, 1'b0);
    chk({nm, ".in_ready"}, in_ready, 1'b1);
  endtask

  // Reference model from the opcode rules, using wide signed/unsigned arithmetic
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] fs, input int sh);
    res_t        r;
    longint      sa, sb, s;
    longint      maxs, mins;
    logic [63:0] p;
    r = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxs = 64'sd2147483647;
    mins = -64'sd2147483648;
    case (fs)
      5'b00000: r.f = a;
      5'b00001: begin r.f = a + 1; r.c = (a == 32'hFFFFFFFF); s = sa + 1; r.v = (s > maxs); end
      5'b00010: begin
        r.f = a + b; p = {32'b0, a} + {32'b0, b}; r.c = (p >= 64'h1_0000_0000);
        s = sa + sb; r.v = (s > maxs) || (s < mins);
      end
      5'b00101: begin r.f = a - b; r.c = (a >= b); s = sa - sb; r.v = (s > maxs) || (s < mins); end
      5'b00110: begin r.f = a - 1; r.c = (a != 0); s = sa - 1; r.v = (s < mins); end
      5'b01000: r.f = a & b;
      5'b01010: r.f = a | b;
      5'b01100: r.f = a ^ b;
      5'b01110: r.f = ~a;
      5'b10000: r.f = b;
      5'b10100: begin r.f = a >> sh; r.rco = (sh != 0) && a[sh-1]; end
      5'b10110: begin
        r.f = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
        r.rco = (sh != 0) && a[sh-1];
      end
      5'b11000: begin r.f = a << sh; r.lco = (sh != 0) && a[32-sh]; end
`ifdef EX_MUL_EN
      5'b11100: begin p = {32'b0, a} * {32'b0, b}; r.f = p[31:0]; r.c = (p[63:32] != 0); r.v = r.c; end
`endif
      default: r.f = '0;
    endcase
    r.n = r.f[31];
    r.z = (r.f == 0);
    r.nxv = r.n ^ r.v;
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  vec_t        vecs[15];
  res_t        e, last_e;
  logic [31:0] last_d, ra, rb;
  logic [15:0] last_raa, last_bra, rpc, bsum;
  logic [4:0]  rfs, rsh;
  logic        rv, rmw;
  int          ops[14];

  initial begin
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 16'h0000, 1'b0, 5'b00010, 5'd0, 32'h80000000, 1, 0, 1, 0, 0, 0};
    vecs[1]  = '{32'h7FF00FFF, 32'h7FFFFFFF, 16'h0000, 1'b0, 5'b00101, 5'd0, 32'hFFF01000, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{32'h00000FFF, 32'h00000FFF, 16'h0000, 1'b0, 5'b00101, 5'd0, 32'h00000000, 0, 1, 0, 1, 0, 0};
    vecs[3]  = '{32'h80000001, 32'h00000000, 16'h0004, 1'b0, 5'b11000, 5'd1, 32'h00000002, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{32'h80000001, 32'h00000000, 16'h0004, 1'b0, 5'b10100, 5'd1, 32'h40000000, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'h80000001, 32'h00000000, 16'h0004, 1'b0, 5'b10110, 5'd1, 32'hC0000000, 0, 0, 1, 0, 0, 1};
    vecs[6]  = '{32'h80000001, 32'h00000000, 16'h0004, 1'b0, 5'b11000, 5'd0, 32'h80000001, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{32'h80000001, 32'h00000000, 16'h0004, 1'b0, 5'b10110, 5'd0, 32'h80000001, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000000, 16'h0000, 1'b0, 5'b00001, 5'd0, 32'h00000000, 0, 1, 0, 1, 0, 0};
    vecs[9]  = '{32'h00000000, 32'h00000000, 16'h0000, 1'b0, 5'b00110, 5'd0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{32'h80000000, 32'h00000000, 16'h0000, 1'b0, 5'b00110, 5'd0, 32'h7FFFFFFF, 1, 1, 0, 0, 0, 0};
    vecs[11] = '{32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 1'b0, 5'b01100, 5'd0, 32'hFF00FF00, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{32'h00000005, 32'h00000003, 16'h0000, 1'b0, 5'b00011, 5'd0, 32'h00000000, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{32'h0F0F0F0F, 32'h00000000, 16'h0000, 1'b0, 5'b01110, 5'd0, 32'hF0F0F0F0, 0, 0, 1, 0, 0, 0};
    vecs[14] = '{32'h00001234, 32'h0000FFF0, 16'h0010, 1'b1, 5'b10000, 5'd0, 32'h0000FFF0, 0, 0, 0, 0, 0, 0};
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b00110, 5'b01000, 5'b01010,
            5'b01100, 5'b01110, 5'b10000, 5'b10100, 5'b10110, 5'b11000, 5'b11100};

    reset = 1'b1;
    drive('0, '0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    chk_zero("reset");
    step();
    step();
    reset = 1'b0;

    // Directed table, applied back-to-back
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].mw, vecs[i].fs, vecs[i].sh, 1'b1);
      step();
      e.f = vecs[i].f; e.v = vecs[i].v; e.c = vecs[i].c; e.n = vecs[i].n; e.z = vecs[i].z;
      e.nxv = vecs[i].n ^ vecs[i].v; e.lco = vecs[i].lco; e.rco = vecs[i].rco;
      bsum = vecs[i].pc + vecs[i].b[15:0];
      chk_res($sformatf("vec%0d", i), e, vecs[i].b, vecs[i].a[15:0], bsum, vecs[i].mw, 1'b1);
      last_e = e; last_d = vecs[i].b; last_raa = vecs[i].a[15:0]; last_bra = bsum;
    end
    chk("movb.BrA_wrap", BrA, 16'h0000);
    in_valid = 1'b0;
    step();
    chk_res("hold", last_e, last_d, last_raa, last_bra, 1'b0, 1'b0);

    // Randomized ops with random gaps in in_valid
    for (int i = 0; i < 300; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      rpc = 16'($urandom);
      rmw = 1'($urandom);
      rfs = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(ops[$urandom_range(0, 13)]);
`ifdef EX_MUL_EN
      if (rfs == 5'b11100) rfs = 5'b00010;
`endif
      rsh = 5'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rpc, rmw, rfs, rsh, rv);
      step();
      if (rv) begin
        last_e = model(ra, rb, rfs, int'(rsh));
        last_d = rb; last_raa = ra[15:0]; last_bra = rpc + rb[15:0];
      end
      chk_res($sformatf("rnd%0d fs=%b", i, rfs), last_e, last_d, last_raa, last_bra, rv & rmw, rv);
      chk("rnd.in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();

`ifdef EX_MUL_EN
    // Multiply with an ADD held on the input during the stall
    drive(32'h00010001, 32'h00010000, 16'h0100, 1'b1, 5'b11100, 5'd0, 1'b1);
    step();
    drive(32'h3, 32'h4, 16'h0005, 1'b0, 5'b00010, 5'd0, 1'b1);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("mul.in_ready_low%0d", i), in_ready, 1'b0);
      chk($sformatf("mul.no_valid%0d", i), out_valid, 1'b0);
      step();
    end
    e = '0; e.f = 32'h00010000; e.c = 1'b1; e.v = 1'b1; e.nxv = 1'b1;
    chk_res("mul", e, 32'h00010000, 16'h0001, 16'h0100, 1'b1, 1'b1);
    chk("mul.in_ready_back", in_ready, 1'b1);
    step();
    e = '0; e.f = 32'h7;
    chk_res("held_add", e, 32'h4, 16'h0003, 16'h0009, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();

    // Random multiplies with bounded wait for completion
    for (int i = 0; i < 6; i++) begin
      int n;
      ra = pick_operand(); rb = pick_operand(); rpc = 16'($urandom); rmw = 1'($urandom);
      drive(ra, rb, rpc, rmw, 5'b11100, 5'($urandom), 1'b1);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 3 * W) begin
        step();
        n++;
      end
      chk($sformatf("rmul%0d.latency", i), n, W);
      chk_res($sformatf("rmul%0d", i), model(ra, rb, 5'b11100, 0), rb, ra[15:0],
              16'(rpc + rb[15:0]), rmw, 1'b1);
      step();
    end

    // Reset 10 cycles into a multiply aborts it
    drive(32'h12345678, 32'h9ABCDEF0, 16'h0042, 1'b1, 5'b11100, 5'd0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("midmul.busy", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk_zero("midmul_reset");
    step();
    reset = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      chk($sformatf("midmul.no_valid%0d", i), out_valid, 1'b0);
      step();
    end
`else
    // Without the multiplier, FS=11100 is an undefined op with latency 1
    drive(32'h00010001, 32'h00010000, 16'h0100, 1'b0, 5'b11100, 5'd0, 1'b1);
    step();
    e = '0; e.z = 1'b1;
    chk_res("nomul", e, 32'h00010000, 16'h0001, 16'h0100, 1'b0, 1'b1);
    chk("nomul.in_ready", in_ready, 1'b1);
    drive(32'h5, 32'h6, 16'h0001, 1'b1, 5'b00010, 5'd0, 1'b1);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    step();
    reset = 1'b0;
    step();
    chk("after_reset.no_valid", out_valid, 1'b0);
`endif

    drive(32'h1, 32'h1, 16'h0000, 1'b0, 5'b00010, 5'd0, 1'b1);
    step();
    e = '0; e.f = 32'h2;
    chk_res("post_reset_add", e, 32'h1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage for the pipelined datapath: WIDTH-bit ALU/shifter with status flags, branch/jump address generation and store-data pass-through. It registers every result and adds a valid/ready handshake. An optional iterative multiplier stalls the stage. It sits between the decode/operand-fetch stage and the memory stage.

## Interface
- WIDTH, 32: datapath width (≥4, power of two).
- ADDR_W, 16: PC/address width (≤ WIDTH).
- SHW, $clog2(WIDTH): shift-amount width (derived localparam).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- in_valid  in  1  operand/op presented this cycle.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready at rising edge.
- ABUS, BBUS  in  WIDTH  operands A, B.
- PCN2  in  ADDR_W  PC+2 of the instruction.
- MW  in  1  memory-write request.
- FS  in  5  function select.
- SH  in  SHW  shift amount.
- out_valid  out  1  one-cycle pulse: registered result valid.
- F  out  WIDTH  result.
- data  out  WIDTH  store data (= B).
- RAA  out  ADDR_W  register jump address A[ADDR_W-1:0].
- BrA  out  ADDR_W  branch target PCN2 + B[ADDR_W-1:0], modulo 2^ADDR_W.
- MW_out  out  1  MW qualified by out_valid.
- V, C, N, Z, NXORV, LCO, RCO  out  1 each  status flags.

## Operation
- FS: 00000 MOVA; 00001 INC A+1; 00010 ADD A+B; 00101 SUB A+~B+1; 00110 DEC A-1; 01000 AND; 01010 OR; 01100 XOR; 01110 NOT A; 10000 MOVB; 10100 SRL A>>SH; 10110 SRA; 11000 SLL A<<SH; 11100 MUL (low WIDTH bits of A*B, unsigned); others: F=0.
- C: carry out of bit WIDTH-1 for INC/ADD/SUB/DEC (SUB: C=1 iff A≥B unsigned); V: signed overflow for same ops. MUL: C=V=1 iff upper WIDTH product bits nonzero. All other ops C=V=0.
- N=F[WIDTH-1], Z=(F==0), NXORV=N^V, always.
- LCO=A[WIDTH-SH] for SLL, RCO=A[SH-1] for SRL/SRA; both 0 when SH=0 or op not that shift.
- States IDLE, MUL. IDLE: in_ready=1. Accept non-MUL -> results registered at that edge, out_valid=1 next cycle, stay IDLE. Accept MUL -> latch A, B, PCN2, MW; count=WIDTH; go MUL.
- MUL: in_ready=0; per edge shift-add one multiplier bit, count-1; on edge where count reaches 0 register F/flags/addresses, out_valid=1, return IDLE.
- in_valid while in_ready=0: ignored; upstream holds operands.
- F, flags, data, RAA, BrA hold last registered value while out_valid=0; MW_out=0 whenever out_valid=0.

## Timing
- Reset: all outputs 0, in_ready=1, state IDLE, count 0. Reset mid-MUL aborts; no out_valid for that op.
- Non-MUL latency 1: accept at edge k, out_valid high cycle after k. Back-to-back accepts every cycle, out_valid high continuously.
- MUL latency WIDTH: accept at edge k, in_ready low after k through edge k+WIDTH, out_valid and in_ready both high after edge k+WIDTH. Next op accepted at edge k+WIDTH+1 at earliest.
- No output backpressure: downstream always consumes out_valid.

## Configuration
- EX_MUL_EN defined: MUL state, iterative multiplier and counter compiled in, as above.
- Undefined: FS=11100 is undefined (F=0, flags per rules, latency 1); in_ready tied 1; no MUL state or counter.

## Test plan
- ADD A=7FFFFFFF B=00000001 FS=00010 -> next cycle out_valid=1, F=80000000, V=1 C=0 N=1 Z=0 NXORV=0.
- SUB A=7FF00FFF B=7FFFFFFF FS=00101 -> F=FFF01000, C=0 V=0 N=1 Z=0 NXORV=1; A=B=00000FFF -> F=0, Z=1, C=1.
- A=80000001 SH=1: SLL -> F=00000002 LCO=1; SRL -> F=40000000 RCO=1; SRA -> F=C0000000 RCO=1; SH=0 -> LCO=RCO=0.
- MW=1 PCN2=0010 A=00001234 B=0000FFF0 FS=10000 -> BrA=0000 (wrap), RAA=1234, data=0000FFF0, MW_out high exactly one cycle.
- EX_MUL_EN: A=00010001 B=00010000 FS=11100 -> in_ready low 32 cycles, ADD held on in_valid meanwhile not accepted, then F=00010000 C=V=1; held ADD accepted next edge.
- Assert reset 10 cycles into MUL -> all outputs 0, in_ready=1 immediately, no out_valid; after release ADD 1+1 -> F=00000002.
